// File: rtl/up_dn_cmd_seq_pkg.sv
// Shared types for the up/down counter command sequencer: opcodes, FSM states
// and the 7-bit queued command entry {op, arg}.
package up_dn_cmd_pkg;

  localparam int ARG_W = 5;
  localparam int CMD_W = 2 + ARG_W;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_HOLD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EXEC_LOAD = 2'd1,
    S_EXEC_STEP = 2'd2,
    S_EXEC_HOLD = 2'd3
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [ARG_W-1:0] arg;
  } cmd_t;

  function automatic state_e op_to_state(op_e op);
    case (op)
      OP_LOAD:         return S_EXEC_LOAD;
      OP_UP, OP_DOWN:  return S_EXEC_STEP;
      default:         return S_EXEC_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/up_dn_cmd_seq_if.sv
// Command handshake, counter feedback and counter control bundle.
// master = command source / counter side, slave = the sequencer.
interface up_dn_cmd_seq_if;
  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic [1:0] Cmd_Op;
  logic [4:0] Cmd_Arg;
  logic       High;
  logic       Low;
  logic [4:0] IN;
  logic       Load;
  logic       Up;
  logic       Down;
  logic       Busy;

  modport master (
    output Cmd_Valid, Cmd_Op, Cmd_Arg, High, Low,
    input  Cmd_Ready, IN, Load, Up, Down, Busy
  );

  modport slave (
    input  Cmd_Valid, Cmd_Op, Cmd_Arg, High, Low,
    output Cmd_Ready, IN, Load, Up, Down, Busy
  );
endinterface

// File: rtl/up_dn_cmd_seq_cmd_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with full/empty flags; pushes while full and
// pops while empty are ignored, a simultaneous push and pop both take effect.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             wr_en, rd_en;

  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/up_dn_cmd_seq.sv
// Queues LOAD/UP/DOWN/HOLD commands and sequences them onto an external up/down
// counter; steps are gated and aborted by the counter's High/Low saturation flags.
module up_dn_cmd_seq
  import up_dn_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  up_dn_cmd_seq_if.slave bus
);
  state_e           state_q, state_d;
  logic [ARG_W-1:0] cnt_q, cnt_d;
  logic [ARG_W-1:0] in_q, in_d;
  logic             dir_up_q, dir_up_d;
  logic             rdy_en_q;

  logic             fifo_full, fifo_empty, push, pop;
  logic [CMD_W-1:0] fifo_rdata;
  cmd_t             head;
  logic             sat, load, up, dn;

  // Ready stays low through reset and comes up one edge after release.
  assign bus.Cmd_Ready = rdy_en_q & ~fifo_full;
  assign push          = bus.Cmd_Valid & bus.Cmd_Ready;
  assign head          = cmd_t'(fifo_rdata);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.Cmd_Op, bus.Cmd_Arg}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      in_q     <= '0;
      dir_up_q <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_q     <= in_d;
      dir_up_q <= dir_up_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_d     = in_q;
    dir_up_d = dir_up_q;
    pop      = 1'b0;
    load     = 1'b0;
    up       = 1'b0;
    dn       = 1'b0;
    sat      = dir_up_q ? bus.High : bus.Low;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          cnt_d    = head.arg;
          dir_up_d = (head.op == OP_UP);
          if (head.op == OP_LOAD) in_d = head.arg;
          state_d  = op_to_state(head.op);
        end
      end
      S_EXEC_LOAD: begin
        load    = 1'b1;
        state_d = S_IDLE;
      end
      S_EXEC_STEP: begin
        // A zero count retires silently; saturation gates the pulse and aborts.
        if (cnt_q != '0 && !sat) begin
          up = dir_up_q;
          dn = ~dir_up_q;
        end
        if (cnt_q <= 5'd1 || sat) state_d = S_IDLE;
        else                      cnt_d   = cnt_q - 5'd1;
      end
      S_EXEC_HOLD: begin
        if (cnt_q <= 5'd1) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 5'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.IN   = in_q;
  assign bus.Load = load;
  assign bus.Up   = up;
  assign bus.Down = dn;
  assign bus.Busy = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: doc/up_dn_cmd_seq.md
UP_DN_CMD_SEQ -- requirements
Module: up_dn_cmd_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of queued commands (power of two, >=2).
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 Cmd_Valid  input  1  upstream command present.
REQ-005 Cmd_Ready  output  1  block can accept a command this cycle.
REQ-006 Cmd_Op  input  2  opcode: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
REQ-007 Cmd_Arg  input  5  LOAD value, or step or cycle count.
REQ-008 High  input  1  counter-at-maximum flag fed back from the up/down counter.
REQ-009 Low  input  1  counter-at-zero flag fed back from the up/down counter.
REQ-010 IN  output  5  load value driven to the counter, registered.
REQ-011 Load / Up / Down  output  1 each  counter controls, one-hot or all zero.
REQ-012 Busy  output  1  high while any command is queued or executing.

Function
REQ-013 A command SHALL be accepted on a rising edge with Cmd_Valid=1 and Cmd_Ready=1.
REQ-014 Cmd_Ready SHALL equal "FIFO not full"; Cmd_Op and Cmd_Arg SHALL be captured together.
REQ-015 FSM states SHALL be IDLE, EXEC_LOAD, EXEC_STEP and EXEC_HOLD.
REQ-016 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry on the next edge and enter the state for that opcode.
REQ-017 The first output cycle SHALL be the cycle after the pop edge, giving a minimum two-edge latency from acceptance.
REQ-018 A command with Arg=0 and opcode UP, DOWN or HOLD SHALL retire in one cycle with Load, Up and Down low.
REQ-019 EXEC_LOAD: IN SHALL update to Arg at the pop edge; Load=1 for exactly one cycle; then IDLE.
REQ-020 IN SHALL hold its last loaded value at all other times.
REQ-021 EXEC_STEP (UP): a 5-bit remaining count SHALL be loaded with Arg; Up=1 each cycle; count decrements per cycle; IDLE after exactly Arg Up cycles.
REQ-022 EXEC_STEP (DOWN): same rules as REQ-021, driving Down instead of Up.
REQ-023 Saturation: during UP, if High=1 in a cycle, Up SHALL be 0 that cycle (combinational gate) and the command SHALL abort to IDLE at the next edge.
REQ-024 Saturation: during DOWN, Low=1 SHALL do the same as REQ-023, gating Down.
REQ-025 EXEC_HOLD: all controls SHALL stay low for Arg cycles, then IDLE.
REQ-026 Back-to-back: the return to IDLE and the next pop SHALL each take one edge, so consecutive commands are separated by one idle cycle.
REQ-027 A push and a pop on the same edge SHALL both take effect, leaving occupancy unchanged.
REQ-028 When the FIFO is full, Cmd_Ready SHALL be 0 and Cmd_Valid SHALL be ignored.
REQ-029 Busy SHALL equal (state != IDLE) OR (FIFO non-empty).

Reset
REQ-030 While RST=0: state=IDLE, FIFO empty, IN=0, Load=Up=Down=0, Busy=0, Cmd_Ready=0.
REQ-031 Cmd_Ready SHALL rise on the first edge after reset release.
REQ-032 Reset asserted mid-command SHALL abort immediately with no further control pulses; queued commands SHALL be discarded.

Structure
REQ-033 Package up_dn_cmd_pkg SHALL hold the opcode constants, FSM state encoding and the 7-bit command entry width.
REQ-034 Sub-module cmd_fifo (synchronous FIFO, FIFO_DEPTH x 7 bits, full/empty flags) SHALL hold the command queue.
REQ-035 The FSM, remaining counter and IN register SHALL live in up_dn_cmd_seq.

Verification
REQ-036 Reset release, then LOAD 5 -> IN=5 and a single-cycle Load pulse two edges after acceptance.
REQ-037 LOAD 5, then UP 3, with the counter model attached -> three Up cycles, final count 8, Busy then falls.
REQ-038 LOAD 29, then UP 10 -> Up is gated when High asserts at 31, the command aborts and the count stays 31.
REQ-039 LOAD 2, then DOWN 5 -> Down is gated at Low, the count stays 0, and the next queued command executes.
REQ-040 Push 5 commands with no pop possible -> Cmd_Ready=0 after 4 pushes and the 5th is not accepted until a pop.
REQ-041 Assert RST mid-way through UP 20 -> Up=0 immediately, Busy=0, the FIFO is empty, and a new LOAD 7 works after release.
